// File: rtl/spin_cmd_receiver.sv
// spin_cmd_receiver: receive-only SPI (mode 0, MSB first) front end that
// validates 16-bit spin commands, hands the three sprite codes plus a
// start_spin pulse to memory_controller, and tracks the spin via its done.
module spin_cmd_receiver #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] HEADER      = 4'hA
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       mosi,
    input  logic       spin_done,
    output logic [2:0] final1_sprite,
    output logic [2:0] final2_sprite,
    output logic [2:0] final3_sprite,
    output logic       start_spin,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT,
        CHECK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;
    logic                   cs_d;
    logic [1:0]             flush_cnt;
    logic                   done_q;
    logic                   done_qq;
    logic [15:0]            shreg;
    logic [4:0]             bit_cnt;

    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sck_rise;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   settled;
    logic                   done_rise;
    logic                   busy_eff;
    logic                   frame_ok;

    // Synchronize the SPI pins, keep one extra stage for edge detection,
    // register spin_done twice for its rising-edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
            flush_cnt <= '0;
            done_q    <= 1'b0;
            done_qq   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
            if (flush_cnt != 2'(SYNC_STAGES)) begin
                flush_cnt <= flush_cnt + 2'd1;
            end
            done_q    <= spin_done;
            done_qq   <= done_q;
        end
    end

    // Edge detects, done-before-check ordering and frame validation.
    always_comb begin
        sck_s     = sck_sync[SYNC_STAGES-1];
        cs_s      = cs_sync[SYNC_STAGES-1];
        mosi_s    = mosi_sync[SYNC_STAGES-1];
        sck_rise  = sck_s & ~sck_d;
        cs_fall   = ~cs_s & cs_d;
        cs_rise   = cs_s & ~cs_d;
        // The synchronizer reset values are not real pin samples; WAIT_IDLE
        // must not trust cs_n until every stage holds a sampled value, or a
        // frame in progress at reset release would be picked up half-way.
        settled   = (flush_cnt == 2'(SYNC_STAGES));
        done_rise = done_q & ~done_qq;
        busy_eff  = busy & ~done_rise;
        frame_ok  = (bit_cnt == 5'd16) &&
                    (shreg[15:12] == HEADER) &&
                    (shreg[2:0] == (shreg[11:9] ^ shreg[8:6] ^ shreg[5:3]));
    end

    // Receive FSM with registered sprites, start pulse, busy tracker and flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= WAIT_IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            final1_sprite <= '0;
            final2_sprite <= '0;
            final3_sprite <= '0;
            start_spin    <= 1'b0;
            busy          <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            start_spin <= 1'b0;
            if (done_rise && busy) begin
                busy <= 1'b0;
            end
            case (state)
                WAIT_IDLE: begin
                    if (settled && cs_s) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (cs_fall) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        shreg <= {shreg[14:0], mosi_s};
                        if (bit_cnt != 5'd17) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    if (cs_rise) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                    end else if (busy_eff) begin
                        overrun <= 1'b1;
                    end else begin
                        final1_sprite <= shreg[11:9];
                        final2_sprite <= shreg[8:6];
                        final3_sprite <= shreg[5:3];
                        start_spin    <= 1'b1;
                        busy          <= 1'b1;
                        frame_err     <= 1'b0;
                        overrun       <= 1'b0;
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spin_cmd_receiver.sv
// tb_spin_cmd_receiver: directed SPI frames; accepted frames push expected
// sprites and start cycle into a queue checked by an independent monitor.
module tb_spin_cmd_receiver;

    logic       clk;
    logic       reset_n;
    logic       sck;
    logic       cs_n;
    logic       mosi;
    logic       spin_done;
    logic [2:0] final1_sprite;
    logic [2:0] final2_sprite;
    logic [2:0] final3_sprite;
    logic       start_spin;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    typedef struct {
        logic [2:0]  f1;
        logic [2:0]  f2;
        logic [2:0]  f3;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;

    spin_cmd_receiver #(
        .SYNC_STAGES(2),
        .HEADER(4'hA)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sck(sck),
        .cs_n(cs_n),
        .mosi(mosi),
        .spin_done(spin_done),
        .final1_sprite(final1_sprite),
        .final2_sprite(final2_sprite),
        .final3_sprite(final3_sprite),
        .start_spin(start_spin),
        .busy(busy),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned got, input int unsigned want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every start_spin pulse.
    logic       prev_start = 1'b0;
    logic       prev_ok = 1'b0;
    logic [8:0] prev_spr = '0;
    always begin
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (start_spin) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_start: start_spin=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                e = q.pop_front();
                chk("sprite1", final1_sprite, e.f1);
                chk("sprite2", final2_sprite, e.f2);
                chk("sprite3", final3_sprite, e.f3);
                chk("start_cycle", cyc, e.cyc);
                chk("busy_with_start", busy, 1);
            end
        end
        chk("start_back_to_back", prev_start & start_spin, 0);
        if (reset_n && prev_ok && !start_spin)
            chk("sprite_hold", {final1_sprite, final2_sprite, final3_sprite}, prev_spr);
        prev_start = start_spin;
        prev_ok    = reset_n;
        prev_spr   = {final1_sprite, final2_sprite, final3_sprite};
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Lower cs_n (no-op if already low) and shift nbits of data MSB first.
    task automatic spi_bits(input logic [16:0] data, input int nbits);
        cs_n = 1'b0;
        clks(5);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = data[i];
            clks(5);
            sck = 1'b1;
            clks(5);
            sck = 1'b0;
        end
        clks(5);
    endtask

    // Raise cs_n now; the pin is captured at the next edge, start_spin 3 edges later.
    task automatic raise_cs(input bit accept, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        exp_t e;
        cs_n = 1'b1;
        if (accept) begin
            e.f1  = a;
            e.f2  = b;
            e.f3  = c;
            e.cyc = cyc + 4;
            q.push_back(e);
        end
    endtask

    task automatic frame(input logic [16:0] data, input int nbits, input bit accept,
                         input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        spi_bits(data, nbits);
        raise_cs(accept, a, b, c);
        clks(10);
    endtask

    task automatic check_state(input string tag, input logic [8:0] spr, input bit b,
                               input bit fe, input bit ov);
        chk({tag, "_sprites"}, {final1_sprite, final2_sprite, final3_sprite}, spr);
        chk({tag, "_busy"}, busy, b);
        chk({tag, "_frame_err"}, frame_err, fe);
        chk({tag, "_overrun"}, overrun, ov);
    endtask

    // spin_done rises now; busy must still be high one edge later, low after two.
    task automatic done_rise_check(input string tag);
        spin_done = 1'b1;
        @(negedge clk);
        chk({tag, "_busy_hold"}, busy, 1);
        @(negedge clk);
        chk({tag, "_busy_fall"}, busy, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        sck       = 1'b0;
        cs_n      = 1'b1;
        mosi      = 1'b0;
        spin_done = 1'b0;
        clks(3);
        chk("reset_start", start_spin, 0);
        check_state("reset", 9'o000, 0, 0, 0);
        reset_n = 1'b1;
        clks(6);

        // Valid frame 0xAAB8 -> 5/2/7, then done clears busy two cycles later
        frame(17'h0AAB8, 16, 1, 3'd5, 3'd2, 3'd7);
        check_state("valid", 9'o527, 1, 0, 0);
        done_rise_check("done1");
        clks(3);
        spin_done = 1'b0;
        clks(3);

        // Second frame while busy -> overrun, sprites held
        frame(17'h0AAB8, 16, 1, 3'd5, 3'd2, 3'd7);
        frame(17'h0A298, 16, 0, 3'd0, 3'd0, 3'd0);
        check_state("overrun", 9'o527, 1, 0, 1);
        done_rise_check("done2");
        spin_done = 1'b0;
        clks(3);
        frame(17'h0A298, 16, 1, 3'd1, 3'd2, 3'd3);
        check_state("after_overrun", 9'o123, 1, 0, 0);

        // Clear busy, keep spin_done high (stale) for the malformed frames
        done_rise_check("done3");
        clks(3);
        frame(17'h0A299, 16, 0, 3'd0, 3'd0, 3'd0);
        check_state("bad_checksum", 9'o123, 0, 1, 0);
        frame(17'h0B298, 16, 0, 3'd0, 3'd0, 3'd0);
        check_state("bad_header", 9'o123, 0, 1, 0);
        frame(17'h02298, 15, 0, 3'd0, 3'd0, 3'd0);
        check_state("short_frame", 9'o123, 0, 1, 0);
        frame(17'h1A298, 17, 0, 3'd0, 3'd0, 3'd0);
        check_state("long_frame", 9'o123, 0, 1, 0);

        // Stale done: spin_done still high from the previous spin
        frame(17'h0A298, 16, 1, 3'd1, 3'd2, 3'd3);
        check_state("stale_accept", 9'o123, 1, 0, 0);
        clks(10);
        chk("stale_busy_held", busy, 1);
        spin_done = 1'b0;
        clks(3);
        chk("stale_busy_after_low", busy, 1);
        done_rise_check("done4");
        spin_done = 1'b0;
        clks(3);

        // Done rising edge detected in the same cycle as CHECK
        frame(17'h0A298, 16, 1, 3'd1, 3'd2, 3'd3);
        chk("pre_align_busy", busy, 1);
        spi_bits(17'h0AAB8, 16);
        raise_cs(1, 3'd5, 3'd2, 3'd7);
        @(negedge clk);
        @(negedge clk);
        spin_done = 1'b1;
        clks(8);
        check_state("same_cycle", 9'o527, 1, 0, 0);
        spin_done = 1'b0;
        clks(3);

        // Reset after 8 bits, release with cs_n low, finish the frame
        spi_bits(17'h000A2, 8);
        reset_n = 1'b0;
        clks(2);
        check_state("mid_reset", 9'o000, 0, 0, 0);
        reset_n = 1'b1;
        spi_bits(17'h00098, 8);
        raise_cs(0, 3'd0, 3'd0, 3'd0);
        clks(10);
        check_state("post_reset", 9'o000, 0, 0, 0);
        frame(17'h0A298, 16, 1, 3'd1, 3'd2, 3'd3);
        check_state("post_reset_accept", 9'o123, 1, 0, 0);

        clks(5);
        chk("pending_starts", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spin_cmd_receiver.md
# spin_cmd_receiver

Upstream front end of the FPGA display path. Receives spin commands from the microcontroller over a receive-only SPI link (mode 0, MSB first), validates each 16-bit frame, and drives `final1_sprite`/`final2_sprite`/`final3_sprite` and a one-cycle `start_spin` pulse into `memory_controller`. It also tracks the spin in progress using `memory_controller`'s `done`, and reports `busy` and error flags back to the microcontroller.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on `sck`, `cs_n` and `mosi`; legal values are 2 or 3.
- `HEADER`, default 4'hA: required value of frame bits [15:12].
- `clk`  in  1: system clock, the same clock used by `memory_controller` and `vga_controller`.
- `reset_n`  in  1: asynchronous, active-low reset.
- `sck`  in  1: SPI clock from the MCU, asynchronous to `clk`; its frequency must not exceed f(clk)/8.
- `cs_n`  in  1: SPI chip select, active low, asynchronous.
- `mosi`  in  1: SPI data, asynchronous.
- `spin_done`  in  1: `done` from `memory_controller`.
- `final1_sprite`, `final2_sprite`, `final3_sprite`  out  3 each: sprite codes of the most recently accepted frame.
- `start_spin`  out  1: one-cycle pulse issued per accepted frame.
- `busy`  out  1: high from `start_spin` until the spin completes; routed to an MCU GPIO.
- `frame_err`  out  1: sticky flag for a malformed frame.
- `overrun`  out  1: sticky flag for a valid frame that arrived while `busy` was high.

## Operation
- **Synchronization:** all three SPI inputs pass through `SYNC_STAGES` flops. Reset values are `sck`=0, `cs_n`=1, `mosi`=0. Edge detection compares the last synchronizer stage with one further register.
- **Frame format:** [15:12] = `HEADER`, [11:9] = f1, [8:6] = f2, [5:3] = f3, [2:0] = f1^f2^f3 (checksum).
- **RX FSM, state WAIT_IDLE** (the reset state): leave when synced `cs_n` is 1, going to IDLE. This means a frame already in progress when reset deasserts is ignored.
- **RX FSM, state IDLE:** on a synced `cs_n` falling edge, clear the 16-bit shift register and the 5-bit bit counter, then go to SHIFT.
- **RX FSM, state SHIFT:** on each synced `sck` rising edge, shift left with synced `mosi` entering the LSB. The bit counter increments and saturates at 17. On a synced `cs_n` rising edge, go to CHECK.
- **RX FSM, state CHECK** (one cycle, then IDLE):
  - The frame is valid when count == 16, header matches, and checksum matches.
  - Valid and not busy: latch the sprites, pulse `start_spin`, set `busy`, and clear `frame_err` and `overrun`.
  - Valid and busy: set `overrun`. The sprites are unchanged and there is no pulse.
  - Invalid: set `frame_err`. Nothing else changes.
- **Spin tracker:**
  - `busy` sets on the cycle `start_spin` is high.
  - `busy` clears on the cycle after a 0->1 transition of `spin_done` is seen while `busy`=1.
  - A `spin_done` that is still held high from the previous spin does not clear `busy`.
- **Simultaneous events:** when a `spin_done` rising edge and CHECK land in the same cycle, the done is applied first, so the frame is accepted and `overrun` is not set.
- **Output stability:** the sprite outputs change only in the cycle `start_spin` is high, and hold until the next accepted frame.

## Timing
- **Reset values:** sprites 0, `start_spin` 0, `busy` 0, `frame_err` 0, `overrun` 0. FSM in WAIT_IDLE, counter 0.
- **Assertion of reset mid-frame or mid-spin:** all state is cleared immediately (asynchronous). The partial frame is discarded.
- **Latency to `start_spin`:** `start_spin` and the new sprite values are registered together. With SYNC_STAGES = 2, they appear on the 4th `clk` rising edge after the pin `cs_n` rise is captured (SYNC_STAGES + 2 in general).
- **`start_spin` width:** exactly one cycle per accepted frame, never back-to-back.
- **`busy` rise:** `busy` rises in the same cycle as `start_spin`.
- **`busy` fall:** `busy` falls 2 cycles after a `spin_done` rising edge at the input (1 edge-detect register + 1).
- **Flag update:** `frame_err` and `overrun` update in the cycle after CHECK.
- **Inter-frame gap:** `cs_n` must stay high for at least SYNC_STAGES+3 `clk` cycles; shorter gaps are outside the spec.

## Test plan
- **Valid frame:** frame 0xAAB8 (f = 5, 2, 7) with `busy`=0 -> sprites 5/2/7, one `start_spin` pulse, `busy`=1. Then pulse `spin_done` 0->1 -> `busy`=0 two cycles later.
- **Second frame while busy:** send 0xAAB8 and then 0xA298 (1/2/3) before `done` -> `overrun`=1, sprites remain 5/2/7, only one `start_spin`. After `done`, send 0xA298 -> sprites 1/2/3, `overrun` cleared.
- **Malformed frames:** 0xA299 (bad checksum), 0xB298 (bad header), 15-bit frame, 17-bit frame -> `frame_err`=1 each time, no `start_spin`, sprites unchanged.
- **Stale `done`:** hold `spin_done`=1 from the previous spin, then accept 0xA298 -> `busy` stays 1 until `spin_done` goes 0 and then 1.
- **Same-cycle done and CHECK:** align the `spin_done` rising edge with the CHECK cycle of 0xAAB8 -> frame accepted, `overrun`=0, `busy`=1.
- **Reset mid-frame:** assert `reset_n` low after 8 bits, release with `cs_n` still low, finish the frame -> no `start_spin`, no `frame_err`, all outputs 0. The next full 0xA298 is accepted normally.
